// File: rtl/msg_schedule_iter_if.sv
// msg_schedule_iter_if: block-in / W-word-out handshake bundle for the schedule engine
interface msg_schedule_iter_if #(
  parameter int WORD_NUM = 16,
  parameter int DATA_WID = 32,
  parameter int CNT_WID  = 6
);
  logic [WORD_NUM*DATA_WID-1:0] iv_m_data;
  logic                         i_m_data_vld;
  logic                         o_m_data_rdy;
  logic [DATA_WID-1:0]          ov_w_data;
  logic [CNT_WID-1:0]           ov_w_index;
  logic                         o_w_data_vld;
  logic                         o_w_last;
  logic                         i_w_data_rdy;
  logic                         o_busy;
  modport slave (
    input  iv_m_data, i_m_data_vld, i_w_data_rdy,
    output o_m_data_rdy, ov_w_data, ov_w_index, o_w_data_vld, o_w_last, o_busy
  );
  modport master (
    output iv_m_data, i_m_data_vld, i_w_data_rdy,
    input  o_m_data_rdy, ov_w_data, ov_w_index, o_w_data_vld, o_w_last, o_busy
  );
endinterface

// File: rtl/msg_schedule_iter.sv
// msg_schedule_iter: iterative SHA-256 message schedule, 16-word sliding window; EXT_MSG_PRELOAD_EN enables bubble-free block chaining
module msg_schedule_iter #(
  parameter int WORD_NUM  = 16,
  parameter int DATA_WID  = 32,
  parameter int ROUND_NUM = 64,
  parameter int CNT_WID   = 6
) (
  input logic clk,
  input logic rst,
  msg_schedule_iter_if.slave bus
);
  typedef enum logic [1:0] {ST_RST, ST_IDLE, ST_RUN} state_t;
  state_t state_q, state_d;
  logic [CNT_WID-1:0] cnt_q, cnt_d;
  logic [DATA_WID-1:0] win_q [WORD_NUM];
  logic [DATA_WID-1:0] win_d [WORD_NUM];
  logic [DATA_WID-1:0] w_new;
  logic run, last, beat, accept;
  function automatic logic [DATA_WID-1:0] rotr(input logic [DATA_WID-1:0] x, input int n);
    return (x >> n) | (x << (DATA_WID - n));
  endfunction
  function automatic logic [DATA_WID-1:0] rou0(input logic [DATA_WID-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [DATA_WID-1:0] rou1(input logic [DATA_WID-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
  // next state, counter, window and handshake outputs; ST_RST holds rdy low one cycle after reset
  always_comb begin
    run  = state_q == ST_RUN;
    last = run && cnt_q == CNT_WID'(ROUND_NUM - 1);
    beat = run && bus.i_w_data_rdy;
`ifdef EXT_MSG_PRELOAD_EN
    bus.o_m_data_rdy = state_q == ST_IDLE || (last && bus.i_w_data_rdy);
`else
    bus.o_m_data_rdy = state_q == ST_IDLE;
`endif
    accept = bus.i_m_data_vld && bus.o_m_data_rdy;
    w_new  = rou1(win_q[14]) + win_q[9] + rou0(win_q[1]) + win_q[0];
    state_d = state_q == ST_RST ? ST_IDLE : accept ? ST_RUN : (beat && last) ? ST_IDLE : state_q;
    cnt_d = (accept || (beat && last)) ? '0 : beat ? cnt_q + CNT_WID'(1) : cnt_q;
    for (int i = 0; i < WORD_NUM - 1; i++)
      win_d[i] = accept ? bus.iv_m_data[DATA_WID*i +: DATA_WID] : beat ? win_q[i+1] : win_q[i];
    win_d[WORD_NUM-1] = accept ? bus.iv_m_data[DATA_WID*(WORD_NUM-1) +: DATA_WID] :
                        beat ? w_new : win_q[WORD_NUM-1];
    bus.o_w_data_vld = run;
    bus.o_w_last     = last;
    bus.o_busy       = run;
    bus.ov_w_data    = win_q[0];
    bus.ov_w_index   = cnt_q;
  end
  // control state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // window contents are don't-care after reset, so no reset term
  always_ff @(posedge clk) begin
    win_q <= win_d;
  end
endmodule

// File: tb/tb_msg_schedule_iter.sv
// tb_msg_schedule_iter: directed checks of the message-schedule engine (64-round and 16-round builds)
module tb_msg_schedule_iter;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int errors = 0;
  logic [511:0] blk_abc, blk_ones, blk16;
  logic [31:0] ref_w [64];

  always #5 clk = ~clk;

  msg_schedule_iter_if #(.CNT_WID(6)) bus ();
  msg_schedule_iter_if #(.CNT_WID(4)) bus16 ();

  msg_schedule_iter #(.ROUND_NUM(64), .CNT_WID(6)) dut (.clk(clk), .rst(rst), .bus(bus));
  msg_schedule_iter #(.ROUND_NUM(16), .CNT_WID(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction
  function automatic logic [31:0] s0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ {3'b0, x[31:3]};
  endfunction
  function automatic logic [31:0] s1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ {10'b0, x[31:10]};
  endfunction

  task automatic gen_ref(input logic [511:0] blk);
    for (int t = 0; t < 16; t++) ref_w[t] = blk[32*t +: 32];
    for (int t = 16; t < 64; t++) ref_w[t] = s1(ref_w[t-2]) + ref_w[t-7] + s0(ref_w[t-15]) + ref_w[t-16];
  endtask

  task automatic send_block(input logic [511:0] blk);
    bit acc;
    bit ok;
    ok = 0;
    bus.iv_m_data = blk;
    bus.i_m_data_vld = 1;
    for (int k = 0; k < 200; k++) begin
      acc = bus.o_m_data_rdy;
      @(negedge clk);
      if (acc) begin ok = 1; break; end
    end
    bus.i_m_data_vld = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL send_block: accept timeout, rdy=%0b required 1", bus.o_m_data_rdy); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.o_m_data_rdy, bus.o_w_data_vld, bus.o_w_last, bus.o_busy} !== 4'b0000 || bus.ov_w_index !== 6'd0) begin
      errors++;
      $display("FAIL reset_state: rdy/vld/last/busy=%b idx=%0d required 0000 idx=0",
               {bus.o_m_data_rdy, bus.o_w_data_vld, bus.o_w_last, bus.o_busy}, bus.ov_w_index);
    end
    rst = 0;
    @(negedge clk);
    checks++;
    if (bus.o_m_data_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy_rise: rdy=%b required 1", bus.o_m_data_rdy); end
  endtask

  task automatic test_abc();
    gen_ref(blk_abc);
    bus.i_w_data_rdy = 1;
    send_block(blk_abc);
    for (int t = 0; t < 64; t++) begin
      checks++;
      if (bus.o_w_data_vld !== 1'b1 || bus.ov_w_index !== 6'(t) || bus.ov_w_data !== ref_w[t] || bus.o_w_last !== (t == 63)) begin
        errors++;
        $display("FAIL abc_beat t=%0d: vld=%b idx=%0d data=%h last=%b required 1 %0d %h %b",
                 t, bus.o_w_data_vld, bus.ov_w_index, bus.ov_w_data, bus.o_w_last, t, ref_w[t], t == 63);
      end
      if (t == 0 || t == 15 || t == 16 || t == 17 || t == 18) begin
        logic [31:0] hand;
        hand = t == 0 ? 32'h61626380 : t == 15 ? 32'h00000018 : t == 16 ? 32'h61626380 :
               t == 17 ? 32'h000F0000 : 32'h7DA86405;
        checks++;
        if (bus.ov_w_data !== hand) begin errors++; $display("FAIL abc_known W%0d: got %h required %h", t, bus.ov_w_data, hand); end
      end
      if (t == 0) begin
        checks++;
        if (bus.o_busy !== 1'b1 || bus.o_m_data_rdy !== 1'b0) begin
          errors++; $display("FAIL abc_busy: busy=%b rdy=%b required 1 0", bus.o_busy, bus.o_m_data_rdy);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (bus.o_w_data_vld !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_m_data_rdy !== 1'b1) begin
      errors++; $display("FAIL abc_end: vld=%b busy=%b rdy=%b required 0 0 1", bus.o_w_data_vld, bus.o_busy, bus.o_m_data_rdy);
    end
  endtask

  task automatic test_stall();
    int t;
    bit prev_stall;
    logic [31:0] pd;
    logic [5:0] pi;
    gen_ref(blk_abc);
    bus.i_w_data_rdy = 1;
    send_block(blk_abc);
    t = 0;
    prev_stall = 0;
    pd = '0;
    pi = '0;
    for (int c = 0; c < 1000 && t < 64; c++) begin
      bus.i_w_data_rdy = 1'($urandom_range(0, 1));
      checks++;
      if (bus.o_w_data_vld !== 1'b1 || bus.ov_w_index !== 6'(t) || bus.ov_w_data !== ref_w[t] || bus.o_w_last !== (t == 63)) begin
        errors++;
        $display("FAIL stall_beat t=%0d: vld=%b idx=%0d data=%h last=%b required 1 %0d %h %b",
                 t, bus.o_w_data_vld, bus.ov_w_index, bus.ov_w_data, bus.o_w_last, t, ref_w[t], t == 63);
      end
      if (prev_stall) begin
        checks++;
        if (bus.ov_w_data !== pd || bus.ov_w_index !== pi) begin
          errors++; $display("FAIL stall_hold: data=%h idx=%0d required %h %0d", bus.ov_w_data, bus.ov_w_index, pd, pi);
        end
      end
      pd = bus.ov_w_data;
      pi = bus.ov_w_index;
      prev_stall = !bus.i_w_data_rdy;
      if (bus.i_w_data_rdy) t++;
      @(negedge clk);
    end
    checks++;
    if (t != 64 || bus.o_w_data_vld !== 1'b0) begin
      errors++; $display("FAIL stall_done: beats=%0d vld=%b required 64 0", t, bus.o_w_data_vld);
    end
    bus.i_w_data_rdy = 1;
  endtask

  task automatic test_back_to_back();
    int c_last, c_next, gap_req;
    gen_ref(blk_abc);
    bus.i_w_data_rdy = 1;
    bus.iv_m_data = blk_abc;
    bus.i_m_data_vld = 1;
    c_last = -1;
    c_next = -1;
`ifdef EXT_MSG_PRELOAD_EN
    gap_req = 0;
`else
    gap_req = 1;
`endif
    for (int c = 0; c < 300 && c_next < 0; c++) begin
      @(negedge clk);
      if (bus.o_w_data_vld) begin
        checks++;
        if (bus.ov_w_data !== ref_w[bus.ov_w_index]) begin
          errors++; $display("FAIL b2b_data idx=%0d: got %h required %h", bus.ov_w_index, bus.ov_w_data, ref_w[bus.ov_w_index]);
        end
      end
      if (c_last >= 0 && bus.o_w_data_vld && bus.ov_w_index == 6'd0) c_next = c;
      if (c_last < 0 && bus.o_w_last) c_last = c;
    end
    bus.i_m_data_vld = 0;
    checks++;
    if (c_next < 0 || c_next - c_last - 1 != gap_req) begin
      errors++; $display("FAIL b2b_gap: idle cycles=%0d required %0d", c_next - c_last - 1, gap_req);
    end
    for (int k = 0; k < 200; k++) begin
      if (bus.o_w_last) begin @(negedge clk); break; end
      @(negedge clk);
    end
    checks++;
    if (bus.o_w_data_vld !== 1'b0 || bus.o_m_data_rdy !== 1'b1) begin
      errors++; $display("FAIL b2b_drain: vld=%b rdy=%b required 0 1", bus.o_w_data_vld, bus.o_m_data_rdy);
    end
  endtask

  task automatic test_reset_mid();
    bus.i_w_data_rdy = 1;
    send_block(blk_abc);
    for (int k = 0; k < 100; k++) begin
      if (bus.ov_w_index == 6'd20) break;
      @(negedge clk);
    end
    checks++;
    if (bus.ov_w_index !== 6'd20) begin errors++; $display("FAIL rst_mid_reach: idx=%0d required 20", bus.ov_w_index); end
    rst = 1;
    @(negedge clk);
    rst = 0;
    checks++;
    if ({bus.o_w_data_vld, bus.o_w_last, bus.o_busy, bus.o_m_data_rdy} !== 4'b0000 || bus.ov_w_index !== 6'd0) begin
      errors++;
      $display("FAIL rst_mid_state: vld/last/busy/rdy=%b idx=%0d required 0000 idx=0",
               {bus.o_w_data_vld, bus.o_w_last, bus.o_busy, bus.o_m_data_rdy}, bus.ov_w_index);
    end
    @(negedge clk);
    checks++;
    if (bus.o_m_data_rdy !== 1'b1 || bus.o_w_data_vld !== 1'b0) begin
      errors++; $display("FAIL rst_mid_rdy: rdy=%b vld=%b required 1 0", bus.o_m_data_rdy, bus.o_w_data_vld);
    end
  endtask

  task automatic test_all_ones();
    gen_ref(blk_ones);
    bus.i_w_data_rdy = 1;
    send_block(blk_ones);
    for (int t = 0; t < 64; t++) begin
      checks++;
      if (bus.o_w_data_vld !== 1'b1 || bus.ov_w_index !== 6'(t) || bus.ov_w_data !== ref_w[t] || bus.o_w_last !== (t == 63)) begin
        errors++;
        $display("FAIL ones_beat t=%0d: vld=%b idx=%0d data=%h last=%b required 1 %0d %h %b",
                 t, bus.o_w_data_vld, bus.ov_w_index, bus.ov_w_data, bus.o_w_last, t, ref_w[t], t == 63);
      end
      if (t == 0 || t == 16 || t == 17) begin
        logic [31:0] hand;
        hand = t == 0 ? 32'hFFFFFFFF : 32'h203FFFFC;
        checks++;
        if (bus.ov_w_data !== hand) begin errors++; $display("FAIL ones_known W%0d: got %h required %h", t, bus.ov_w_data, hand); end
      end
      @(negedge clk);
    end
    checks++;
    if (bus.o_w_data_vld !== 1'b0) begin errors++; $display("FAIL ones_end: vld=%b required 0", bus.o_w_data_vld); end
  endtask

  task automatic test_round16();
    bit ok;
    ok = 0;
    bus16.i_w_data_rdy = 1;
    bus16.iv_m_data = blk16;
    bus16.i_m_data_vld = 1;
    for (int k = 0; k < 50; k++) begin
      bit acc;
      acc = bus16.o_m_data_rdy;
      @(negedge clk);
      if (acc) begin ok = 1; break; end
    end
    bus16.i_m_data_vld = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL r16_accept: rdy=%b required 1", bus16.o_m_data_rdy); end
    for (int t = 0; t < 16; t++) begin
      checks++;
      if (bus16.o_w_data_vld !== 1'b1 || bus16.ov_w_index !== 4'(t) || bus16.ov_w_data !== blk16[32*t +: 32] || bus16.o_w_last !== (t == 15)) begin
        errors++;
        $display("FAIL r16_beat t=%0d: vld=%b idx=%0d data=%h last=%b required 1 %0d %h %b",
                 t, bus16.o_w_data_vld, bus16.ov_w_index, bus16.ov_w_data, bus16.o_w_last, t, blk16[32*t +: 32], t == 15);
      end
      @(negedge clk);
    end
    checks++;
    if (bus16.o_w_data_vld !== 1'b0 || bus16.o_busy !== 1'b0) begin
      errors++; $display("FAIL r16_end: vld=%b busy=%b required 0 0", bus16.o_w_data_vld, bus16.o_busy);
    end
  endtask

  initial begin
    blk_abc  = {32'h00000018, 448'h0, 32'h61626380};
    blk_ones = '1;
    for (int i = 0; i < 16; i++) blk16[32*i +: 32] = 32'h10000000 + 32'(i) * 32'h01010101;
    bus.iv_m_data = '0;
    bus.i_m_data_vld = 0;
    bus.i_w_data_rdy = 0;
    bus16.iv_m_data = '0;
    bus16.i_m_data_vld = 0;
    bus16.i_w_data_rdy = 0;
    test_reset();
    test_abc();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_all_ones();
    test_round16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
